// File: rtl/reg_univ_pkg.sv
// Shared definitions for the universal shift register family.
//   modo_t    : operation codes carried on the 2-bit modo port
//   pos_width : bit width of the rotation-offset output for a given length
package reg_univ_pkg;

  typedef enum logic [1:0] {
    MODO_HOLD = 2'b00,
    MODO_LOAD = 2'b01,
    MODO_DIR  = 2'b10,
    MODO_ESQ  = 2'b11
  } modo_t;

  // clog2(width), never narrower than one bit.
  function automatic int pos_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/registrador_universal_n_divisor_passo.sv
// Step-rate prescaler (module divisor_passo).
// Counts 0..DIV-1 while enable is high and freezes while it is low; tick is
// asserted combinationally in the cycle whose rising edge completes a period.
// Ports:
//   clk    : system clock
//   rst    : synchronous, active-high reset
//   enable : count this cycle (step mode active)
//   clear  : restart the period from zero
//   tick   : a step executes on the coming edge
module divisor_passo #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the counter sits at 0 == LAST, so every enabled edge ticks.
  assign tick = enable && (cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/registrador_universal_n.sv
// Parametrised universal shift register driving a scrolling display panel.
// Holds a WIDTH-bit message; supports hold, parallel load, and left/right
// rotate or serial shift, with steps paced by a DIV-cycle prescaler.
// Optional build macro: REG_UNIV_CONTADOR_EN enables the rotation-offset
// counter (posicao) and the full-revolution strobe (volta_completa); without
// it both outputs are tied to 0.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   modo           : 00 hold, 01 load, 10 step right, 11 step left
//   circular       : 1 rotate, 0 serial shift with serial_in
//   serial_in      : bit entering the vacated end in serial mode
//   cadeia_de_bits : parallel load data
//   saida_janela   : registered display slice, reg[0] on the MSB
//   passo          : strobe aligned with saida_janela first showing stepped data
//   volta_completa : strobe as posicao returns to 0 after a rotation
//   posicao        : rotation offset modulo WIDTH
module registrador_universal_n
  import reg_univ_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 7,
  parameter int DIV    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     modo,
  input  logic                           circular,
  input  logic                           serial_in,
  input  logic [WIDTH-1:0]               cadeia_de_bits,
  output logic [WINDOW-1:0]              saida_janela,
  output logic                           passo,
  output logic                           volta_completa,
  output logic [pos_width(WIDTH)-1:0]    posicao
);

  localparam int PW = pos_width(WIDTH);

  modo_t             modo_e;
  logic              em_passo;
  logic              tick;
  logic [WIDTH-1:0]  reg_q;
  logic [WIDTH-1:0]  reg_d;
  logic [WINDOW-1:0] janela_d;
  logic              passo_q1;

  assign modo_e   = modo_t'(modo);
  assign em_passo = (modo_e == MODO_DIR) || (modo_e == MODO_ESQ);

  divisor_passo #(.DIV(DIV)) u_divisor_passo (
    .clk    (clk),
    .rst    (rst),
    .enable (em_passo),
    .clear  (modo_e == MODO_LOAD),
    .tick   (tick)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    reg_d = reg_q;
    unique case (modo_e)
      MODO_LOAD: reg_d = cadeia_de_bits;
      MODO_DIR:  if (tick) reg_d = {circular ? reg_q[0] : serial_in, reg_q[WIDTH-1:1]};
      MODO_ESQ:  if (tick) reg_d = {reg_q[WIDTH-2:0], circular ? reg_q[WIDTH-1] : serial_in};
      default:   ;
    endcase
  end

  // Display slice is bit-reversed: reg[0] lands on the leftmost panel column.
  always_comb begin
    janela_d = '0;
    for (int k = 0; k < WINDOW; k++) begin
      janela_d[WINDOW-1-k] = reg_q[k];
    end
  end

  // passo goes through two flops so it coincides with the slice register
  // showing the stepped data, which lags reg_q by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q        <= '0;
      saida_janela <= '0;
      passo_q1     <= 1'b0;
      passo        <= 1'b0;
    end else begin
      reg_q        <= reg_d;
      saida_janela <= janela_d;
      passo_q1     <= tick;
      passo        <= passo_q1;
    end
  end

`ifdef REG_UNIV_CONTADOR_EN
  localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);

  logic [PW-1:0] pos_d;
  logic          volta_d;

  // Circular steps move the offset; a serial step destroys the message
  // alignment, so the offset restarts at 0 without claiming a revolution.
  always_comb begin
    pos_d   = posicao;
    volta_d = 1'b0;
    if (modo_e == MODO_LOAD) begin
      pos_d = '0;
    end else if (tick) begin
      if (!circular) begin
        pos_d = '0;
      end else begin
        if (modo_e == MODO_ESQ) pos_d = (posicao == POS_MAX) ? '0 : posicao + PW'(1);
        else                    pos_d = (posicao == '0) ? POS_MAX : posicao - PW'(1);
        volta_d = (pos_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      posicao        <= '0;
      volta_completa <= 1'b0;
    end else begin
      posicao        <= pos_d;
      volta_completa <= volta_d;
    end
  end
`else
  assign posicao        = '0;
  assign volta_completa = 1'b0;
`endif

endmodule

// File: tb/tb_registrador_universal_n.sv
// Self-checking bench for registrador_universal_n: two instances (DIV=1 and
// DIV=4) share stimulus and are compared every cycle against an arithmetic
// reference model, plus directed scenarios with hand-derived constants.
module tb_registrador_universal_n;
  import reg_univ_pkg::*;

  localparam int W   = 16;
  localparam int WIN = 7;
  localparam int PW  = pos_width(W);
`ifdef REG_UNIV_CONTADOR_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    modo;
  logic          circular;
  logic          serial_in;
  logic [W-1:0]  cad;

  logic [WIN-1:0] saida   [2];
  logic           passo   [2];
  logic           volta   [2];
  logic [PW-1:0]  posicao [2];

  registrador_universal_n #(.WIDTH(W), .WINDOW(WIN), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .modo(modo), .circular(circular), .serial_in(serial_in),
    .cadeia_de_bits(cad), .saida_janela(saida[0]), .passo(passo[0]),
    .volta_completa(volta[0]), .posicao(posicao[0])
  );

  registrador_universal_n #(.WIDTH(W), .WINDOW(WIN), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .modo(modo), .circular(circular), .serial_in(serial_in),
    .cadeia_de_bits(cad), .saida_janela(saida[1]), .passo(passo[1]),
    .volta_completa(volta[1]), .posicao(posicao[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           divs [2] = '{1, 4};
  logic [W-1:0] m_reg  [2];
  int           m_pre  [2];
  int           m_pos  [2];
  bit           m_stepd[2];
  logic [WIN-1:0] e_saida [2];
  bit           e_passo [2];
  bit           e_volta [2];
  int           e_pos   [2];

  function automatic logic [WIN-1:0] janela(input logic [W-1:0] r);
    logic [WIN-1:0] w;
    for (int k = 0; k < WIN; k++) w[WIN-1-k] = r[k];
    return w;
  endfunction

  task automatic model_edge(input int i);
    bit           step;
    logic [W-1:0] r;
    bit           e;
    if (rst) begin
      m_reg[i] = '0; m_pre[i] = 0; m_pos[i] = 0; m_stepd[i] = 0;
      e_saida[i] = '0; e_passo[i] = 0; e_volta[i] = 0; e_pos[i] = 0;
      return;
    end
    r          = m_reg[i];
    e_saida[i] = janela(r);
    e_passo[i] = m_stepd[i];
    e_volta[i] = 0;
    step       = 0;
    if (modo == 2'b01) begin
      m_reg[i] = cad; m_pre[i] = 0; m_pos[i] = 0;
    end else if (modo[1]) begin
      if (m_pre[i] == divs[i] - 1) begin
        step = 1; m_pre[i] = 0;
      end else begin
        m_pre[i]++;
      end
    end
    if (step) begin
      if (modo == 2'b11) begin
        e = circular ? r[W-1] : serial_in;
        m_reg[i] = (r << 1) | W'(e);
      end else begin
        e = circular ? r[0] : serial_in;
        m_reg[i] = (r >> 1) | (W'(e) << (W - 1));
      end
      if (circular) begin
        m_pos[i]   = (modo == 2'b11) ? (m_pos[i] + 1) % W : (m_pos[i] + W - 1) % W;
        e_volta[i] = CONT && (m_pos[i] == 0);
      end else begin
        m_pos[i] = 0;
      end
    end
    m_stepd[i] = step;
    e_pos[i]   = CONT ? m_pos[i] : 0;
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic cycle(input logic r, input logic [1:0] m, input logic c,
                       input logic s, input logic [W-1:0] d);
    rst = r; modo = m; circular = c; serial_in = s; cad = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("saida[%0d]", i),   32'(saida[i]),   32'(e_saida[i]));
      check($sformatf("passo[%0d]", i),   32'(passo[i]),   32'(e_passo[i]));
      check($sformatf("volta[%0d]", i),   32'(volta[i]),   32'(e_volta[i]));
      check($sformatf("posicao[%0d]", i), 32'(posicao[i]), 32'(e_pos[i]));
    end
    @(negedge clk);
  endtask

  task automatic hold();
    cycle(1'b0, 2'b00, 1'b0, 1'b0, '0);
  endtask

  int cnt;
  int first;
  int idx[$];

  initial begin
    rst = 1'b1; modo = 2'b00; circular = 1'b0; serial_in = 1'b0; cad = '0;
    @(negedge clk);
    cycle(1'b1, 2'b00, 1'b0, 1'b0, '0);
    cycle(1'b1, 2'b11, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      check("reset_saida", 32'(saida[i]), 32'h0);
      check("reset_passo", 32'(passo[i]), 32'h0);
    end

    // Load 8001, one circular left step -> 0003, slice 1100000 one cycle later.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h8001);
    cycle(1'b0, 2'b11, 1'b1, 1'b0, '0);
    hold();
    check("t1_saida", 32'(saida[0]), 32'b1100000);
    check("t1_passo", 32'(passo[0]), 32'h1);
    hold();
    check("t1_passo_once", 32'(passo[0]), 32'h0);

    // Load 8001, one circular right step -> C000, posicao 15.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h8001);
    cycle(1'b0, 2'b10, 1'b1, 1'b0, '0);
    check("t2_posicao", 32'(posicao[0]), CONT ? 32'd15 : 32'd0);
    hold();
    check("t2_saida", 32'(saida[0]), 32'h0);

    // Load 1234, 16 circular left steps -> back to 1234, one revolution strobe.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h1234);
    cnt = 0; first = -1;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) cycle(1'b0, 2'b11, 1'b1, 1'b0, '0);
      else         hold();
      if (volta[0]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("t3_volta_count", 32'(cnt), CONT ? 32'd1 : 32'd0);
    if (CONT) check("t3_volta_at", 32'(first), 32'd16);
    check("t3_posicao", 32'(posicao[0]), 32'd0);
    check("t3_saida", 32'(saida[0]), 32'b0010110);

    // Serial shift of ones into an empty register.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cycle(1'b0, 2'b11, 1'b0, 1'b1, '0);
      else       hold();
      if (volta[0]) cnt++;
    end
    check("t4_saida", 32'(saida[0]), 32'b1110000);
    check("t4_posicao", 32'(posicao[0]), 32'd0);
    check("t4_volta_count", 32'(cnt), 32'd0);

    // DIV=4: 12 step cycles -> 3 pulses, 4 apart.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h00FF);
    idx.delete();
    for (int k = 1; k <= 13; k++) begin
      if (k <= 12) cycle(1'b0, 2'b10, 1'b1, 1'b0, '0);
      else         hold();
      if (passo[1]) idx.push_back(k);
    end
    check("t5_pulse_count", 32'(idx.size()), 32'd3);
    if (idx.size() == 3) begin
      check("t5_first", 32'(idx[0]), 32'd5);
      check("t5_gap1", 32'(idx[1] - idx[0]), 32'd4);
      check("t5_gap2", 32'(idx[2] - idx[1]), 32'd4);
    end

    // DIV=4 with a 3-cycle hold after two counts: pulse slips by 3 cycles.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h0F0F);
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k >= 3 && k <= 5) hold();
      else                  cycle(1'b0, 2'b10, 1'b1, 1'b0, '0);
      if (passo[1] && first < 0) first = k;
    end
    check("t5_hold_first", 32'(first), 32'd8);

    // Reset mid-rotation, then resume pacing from scratch.
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 16'h00F0);
    for (int k = 0; k < 22; k++) cycle(1'b0, 2'b11, 1'b1, 1'b0, '0);
    check("t6_posicao_pre", 32'(posicao[1]), CONT ? 32'd5 : 32'd0);
    cycle(1'b1, 2'b11, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      check("t6_rst_saida",   32'(saida[i]),   32'h0);
      check("t6_rst_passo",   32'(passo[i]),   32'h0);
      check("t6_rst_volta",   32'(volta[i]),   32'h0);
      check("t6_rst_posicao", 32'(posicao[i]), 32'h0);
    end
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 2'b10, 1'b1, 1'b0, '0);
      if (passo[1] && first < 0) first = k;
    end
    check("t6_resume_first", 32'(first), 32'd5);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
